// File: rtl/register_file_sb.sv
// Register file with scoreboard: XLEN x NUM_REGS storage, x0 hardwired to zero, per-register busy bits.
// Latency: reads and busy lookups are combinational; writes, issues and busy_count update on the clk edge.
// Backpressure: issue_ready drops while issue_rd is busy and is not being written back this cycle.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding onto the read ports).
module register_file_sb #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]   write_data,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]   read_data1,
  output logic [XLEN-1:0]   read_data2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  output logic [ADDR_W:0]   busy_count
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [ADDR_W:0]     cnt_nxt;
  logic                wr_en;
  logic                iss_en;

  // Indices at or beyond NUM_REGS address nothing.
  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_W);
  endfunction

  assign wr_en  = reg_write && (rd != '0) && in_rng(rd);
  assign iss_en = issue_valid && issue_ready && (issue_rd != '0) && in_rng(issue_rd);

  // A writeback to issue_rd in the same cycle frees the slot, so issue may proceed.
  always_comb begin
    issue_ready = 1'b1;
    if ((issue_rd != '0) && in_rng(issue_rd) && busy[issue_rd] &&
        !(reg_write && (rd == issue_rd)))
      issue_ready = 1'b0;
  end

  // Next busy vector: writeback clears first, then issue sets, so a same-cycle issue wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)
      busy_nxt[rd] = 1'b0;
    if (iss_en)
      busy_nxt[issue_rd] = 1'b1;
  end

  // Population count of the next busy vector, registered alongside the bits.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  // Register storage; reset clears everything, x0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd] <= write_data;
    end
  end

  // Scoreboard bits and their count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
    end
  end

  // Read ports: x0 and out-of-range read as zero and never busy.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    rs1_busy   = 1'b0;
    rs2_busy   = 1'b0;
    if ((rs1 != '0) && in_rng(rs1)) begin
      read_data1 = regs[rs1];
      rs1_busy   = busy[rs1];
    end
    if ((rs2 != '0) && in_rng(rs2)) begin
      read_data2 = regs[rs2];
      rs2_busy   = busy[rs2];
    end
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight writeback so decode sees it this cycle.
    if (wr_en && (rd == rs1)) begin
      read_data1 = write_data;
      rs1_busy   = 1'b0;
    end
    if (wr_en && (rd == rs2)) begin
      read_data2 = write_data;
      rs2_busy   = 1'b0;
    end
`else
    // No forwarding: reads show committed state until the edge.
`endif
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Testbench for register_file_sb: directed scenarios plus random traffic against a reference model.
// Latency: combinational outputs checked mid-cycle, busy_count checked 1 ns after each edge.
// Backpressure: dropped issues are predicted by the model from the busy/writeback rules.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ready;
  logic [5:0]  busy_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  register_file_sb #(.XLEN(32), .NUM_REGS(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .rd(rd), .write_data(write_data),
    .rs1(rs1), .rs2(rs2), .read_data1(read_data1), .read_data2(read_data2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_ready(issue_ready), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic bit model_ready();
    return (issue_rd == 0) || !m_busy[issue_rd] || (reg_write && rd == issue_rd);
  endfunction

  // Apply inputs, then check every combinational output against the model.
  task automatic drive(input bit rw, input logic [4:0] d, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input bit iv, input logic [4:0] ird);
    logic [31:0] e1, e2;
    bit b1, b2;
    reg_write = rw; rd = d; write_data = wd; rs1 = a1; rs2 = a2;
    issue_valid = iv; issue_rd = ird;
    #1;
    e1 = (a1 == 0) ? 32'h0 : m_regs[a1];
    e2 = (a2 == 0) ? 32'h0 : m_regs[a2];
    b1 = m_busy[a1];
    b2 = m_busy[a2];
`ifdef REGFILE_BYPASS_EN
    if (rw && d != 0 && d == a1) begin e1 = wd; b1 = 1'b0; end
    if (rw && d != 0 && d == a2) begin e2 = wd; b2 = 1'b0; end
`endif
    chk("read_data1", 64'(read_data1), 64'(e1));
    chk("read_data2", 64'(read_data2), 64'(e2));
    chk("rs1_busy", 64'(rs1_busy), 64'(b1));
    chk("rs2_busy", 64'(rs2_busy), 64'(b2));
    chk("issue_ready", 64'(issue_ready), 64'(model_ready()));
  endtask

  // Clock edge: advance the model by the architectural rules, then check busy_count.
  task automatic tick();
    bit ready;
    @(posedge clk);
    ready = model_ready();
    if (reg_write && rd != 0) begin
      m_regs[rd] = write_data;
      m_busy[rd] = 1'b0;
    end
    if (issue_valid && ready && issue_rd != 0)
      m_busy[issue_rd] = 1'b1;
    #1;
    chk("busy_count", 64'(busy_count), 64'(model_count()));
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b0, 5'd0, 32'h0, a1, a2, 1'b0, 5'd0);
  endtask

  initial begin
    model_clear();
    // 1. Reset
    #15 reset = 1'b1;
    @(posedge clk); #1;
    idle(5'd5, 5'd10);
    chk("rst_rd1", 64'(read_data1), 64'h0);
    chk("rst_rd2", 64'(read_data2), 64'h0);
    chk("rst_cnt", 64'(busy_count), 64'h0);
    chk("rst_ready", 64'(issue_ready), 64'h1);
    tick();

    // 2. Basic writes and x0
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0); tick();
    drive(1'b1, 5'd10, 32'hCAFEBABE, 5'd0, 5'd0, 1'b0, 5'd0); tick();
    idle(5'd5, 5'd10);
    chk("x5", 64'(read_data1), 64'hDEADBEEF);
    chk("x10", 64'(read_data2), 64'hCAFEBABE);
    tick();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd0); tick();
    idle(5'd0, 5'd0);
    chk("x0", 64'(read_data1), 64'h0);
    tick();

    // 3. Issue, blocked re-issue, writeback
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 5'd7); tick();
    chk("cnt_after_issue", 64'(busy_count), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 5'd7);
    chk("x7_busy", 64'(rs1_busy), 64'h1);
    chk("reissue_blocked", 64'(issue_ready), 64'h0);
    tick();
    chk("cnt_after_drop", 64'(busy_count), 64'd1);
    drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0, 1'b0, 5'd0); tick();
    idle(5'd7, 5'd0);
    chk("x7_data", 64'(read_data1), 64'h12345678);
    chk("x7_free", 64'(rs1_busy), 64'h0);
    chk("cnt_after_wb", 64'(busy_count), 64'd0);
    tick();

    // 4. Same-cycle issue and writeback to a busy register
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9); tick();
    drive(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd0, 1'b1, 5'd9);
    chk("iss_wb_ready", 64'(issue_ready), 64'h1);
    tick();
    chk("iss_wb_cnt", 64'(busy_count), 64'd1);
    idle(5'd9, 5'd0);
    chk("iss_wb_busy", 64'(rs1_busy), 64'h1);
    chk("iss_wb_data", 64'(read_data1), 64'hA5A5A5A5);
    tick();

    // 5. Asynchronous reset mid-cycle
    drive(1'b1, 5'd3, 32'h11111111, 5'd0, 5'd0, 1'b1, 5'd3); tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd4); tick();
    idle(5'd3, 5'd9);
    chk("pre_rst_cnt", 64'(busy_count), 64'd3);
    reset = 1'b0;
    #1;
    chk("arst_cnt", 64'(busy_count), 64'd0);
    chk("arst_rd1", 64'(read_data1), 64'h0);
    chk("arst_rd2", 64'(read_data2), 64'h0);
    chk("arst_busy1", 64'(rs1_busy), 64'h0);
    model_clear();
    #1 reset = 1'b1;
    tick();

    // 6. Writeback read in the same cycle (forwarding behaviour)
    drive(1'b1, 5'd5, 32'h01020304, 5'd0, 5'd0, 1'b0, 5'd0); tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd5); tick();
    drive(1'b1, 5'd5, 32'h0BADF00D, 5'd5, 5'd0, 1'b0, 5'd0);
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", 64'(read_data1), 64'h0BADF00D);
    chk("byp_busy", 64'(rs1_busy), 64'h0);
`else
    chk("nobyp_data", 64'(read_data1), 64'h01020304);
    chk("nobyp_busy", 64'(rs1_busy), 64'h1);
`endif
    tick();
    idle(5'd5, 5'd0);
    chk("post_wb_x5", 64'(read_data1), 64'h0BADF00D);
    tick();

    // Random traffic concentrated on a few registers to provoke hazards
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
